// File: rtl/rc5_block_ctrl_if.sv
// Host-side request/response channel of rc5_block_ctrl: one valid/ready request carrying
// dir/rounds/key/block, and one valid/ready response carrying the result block and error flag.
interface rc5_block_ctrl_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_dir;
  logic [4:0]   req_rounds;
  logic [127:0] req_key;
  logic [31:0]  req_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic         rsp_err;

  modport master (
    output req_valid, req_dir, req_rounds, req_key, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_dir, req_rounds, req_key, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/rc5_block_ctrl.sv
// Single-transaction initiator for the RC5 algo core: accept a block, pulse encrypt/decrypt, wait
// for done, return the result. Optional WAIT watchdog enabled by defining RC5_CTRL_TIMEOUT_EN.
module rc5_block_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst,
  rc5_block_ctrl_if.slave host,
  output logic           core_encrypt,
  output logic           core_decrypt,
  output logic [4:0]     core_num_rounds,
  output logic [127:0]   core_key,
  output logic [31:0]    core_d_in,
  input  logic [31:0]    core_d_out,
  input  logic           core_done,
  output logic           busy
);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

  state_e       state_q, state_d;
  logic         dir_q;
  logic [4:0]   rounds_q;
  logic [127:0] key_q;
  logic [31:0]  din_q;
  logic [31:0]  rsp_data_q, rsp_data_d;
  logic         rsp_err_q, rsp_err_d;
  logic         load;

`ifdef RC5_CTRL_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Command registers feed the core directly and change only on a request accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q    <= 1'b0;
      rounds_q <= '0;
      key_q    <= '0;
      din_q    <= '0;
    end else if (load) begin
      dir_q    <= host.req_dir;
      rounds_q <= host.req_rounds;
      key_q    <= host.req_key;
      din_q    <= host.req_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    load       = 1'b0;
`ifdef RC5_CTRL_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (host.req_valid) begin
          load = 1'b1;
          if (host.req_rounds != 5'd0) begin
            state_d = StStart;
          end else begin
            state_d    = StResp;
            rsp_err_d  = 1'b1;
            rsp_data_d = host.req_data;
          end
        end
      end
      StStart: begin
        state_d = StWait;
`ifdef RC5_CTRL_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        // A done arriving on the expiry cycle still yields a normal response.
        if (core_done) begin
          state_d    = StResp;
          rsp_data_d = core_d_out;
          rsp_err_d  = 1'b0;
        end
`ifdef RC5_CTRL_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          state_d    = StResp;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      StResp: begin
        if (host.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // req_ready is gated by rst so it reads 0 while reset is held.
  assign host.req_ready = (state_q == StIdle) & ~rst;
  assign host.rsp_valid = (state_q == StResp);
  assign host.rsp_data  = rsp_data_q;
  assign host.rsp_err   = rsp_err_q;

  assign core_encrypt    = (state_q == StStart) & ~dir_q;
  assign core_decrypt    = (state_q == StStart) & dir_q;
  assign core_num_rounds = rounds_q;
  assign core_key        = key_q;
  assign core_d_in       = din_q;
  assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_rc5_block_ctrl.sv
// Self-checking bench for rc5_block_ctrl with a behavioural algo core model and a response
// scoreboard. Timeout scenarios are built only when RC5_CTRL_TIMEOUT_EN is defined.
module tb_rc5_block_ctrl;
  localparam int unsigned TimeoutCycles = 8;
  localparam logic [127:0] Key = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rc5_block_ctrl_if host ();

  logic         core_encrypt, core_decrypt, core_done, busy;
  logic [4:0]   core_num_rounds;
  logic [127:0] core_key;
  logic [31:0]  core_d_in, core_d_out;

  rc5_block_ctrl #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .clk             (clk),
    .rst             (rst),
    .host            (host),
    .core_encrypt    (core_encrypt),
    .core_decrypt    (core_decrypt),
    .core_num_rounds (core_num_rounds),
    .core_key        (core_key),
    .core_d_in       (core_d_in),
    .core_d_out      (core_d_out),
    .core_done       (core_done),
    .busy            (busy)
  );

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  // Core model: done pulses model_delay cycles after the start pulse; 0 means never.
  int          model_delay = 5;
  int          model_rem = 0;
  logic        model_done = 1'b0;
  logic [31:0] model_out = '0;
  logic        stray_done = 1'b0;
  int          enc_cnt = 0, dec_cnt = 0, both_cnt = 0;

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (core_encrypt || core_decrypt) begin
      model_out <= core_d_in ^ (core_decrypt ? 32'h5A5A5A5A : 32'hA5A5A5A5);
      model_rem <= model_delay - 1;
      enc_cnt   <= enc_cnt + int'(core_encrypt);
      dec_cnt   <= dec_cnt + int'(core_decrypt);
      both_cnt  <= both_cnt + int'(core_encrypt && core_decrypt);
    end else if (model_rem > 1) begin
      model_rem <= model_rem - 1;
    end else if (model_rem == 1) begin
      model_done <= 1'b1;
      model_rem  <= 0;
    end
  end

  assign core_done  = model_done | stray_done;
  assign core_d_out = stray_done ? 32'hCAFEF00D : model_out;

  task automatic do_accept(input logic dir, input logic [4:0] rounds, input logic [31:0] data,
                           input logic exp_timeout);
    int guard = 0;
    while (host.req_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (host.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: req_ready=%b required 1", host.req_ready);
    end
    host.req_valid  = 1'b1;
    host.req_dir    = dir;
    host.req_rounds = rounds;
    host.req_key    = Key ^ {123'd0, rounds};
    host.req_data   = data;
    if (exp_timeout)        exp_q.push_back({1'b1, 32'h0});
    else if (rounds == 5'd0) exp_q.push_back({1'b1, data});
    else exp_q.push_back({1'b0, data ^ (dir ? 32'h5A5A5A5A : 32'hA5A5A5A5)});
    @(posedge clk); #1;
    host.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 1;
    while (host.rsp_valid !== 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (host.rsp_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1 within 100 cycles", host.rsp_valid);
    end
  endtask

  task automatic check_rsp(input string name);
    logic [32:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: response with empty scoreboard", name);
    end else begin
      exp = exp_q.pop_front();
      if ({host.rsp_err, host.rsp_data} !== exp) begin
        errors++;
        $display("FAIL %s: err/data=%b/%h required %b/%h", name, host.rsp_err, host.rsp_data,
                 exp[32], exp[31:0]);
      end
    end
  endtask

  task automatic handshake();
    host.rsp_ready = 1'b1;
    @(posedge clk); #1;
    host.rsp_ready = 1'b0;
    checks++;
    if (host.req_ready !== 1'b1 || host.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_handshake: ready/valid/busy=%b%b%b required 100", host.req_ready,
               host.rsp_valid, busy);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if ({host.req_ready, host.rsp_valid, host.rsp_data, host.rsp_err, core_encrypt, core_decrypt,
         core_num_rounds, core_key, core_d_in, busy} !== '0) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b data=%h busy=%b required all 0",
               host.req_ready, host.rsp_valid, host.rsp_data, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (host.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: req_ready=%b required 1", host.req_ready);
    end
  endtask

  task automatic test_encrypt();
    int e0 = enc_cnt, d0 = dec_cnt, cyc;
    host.rsp_ready = 1'b1;
    do_accept(1'b0, 5'd12, 32'h12345678, 1'b0);
    checks++;
    if (core_encrypt !== 1'b1 || core_decrypt !== 1'b0 || core_num_rounds !== 5'd12 ||
        core_d_in !== 32'h12345678 || core_key !== (Key ^ 128'd12)) begin
      errors++;
      $display("FAIL enc_start: enc/dec=%b%b rounds=%0d d_in=%h required 10 12 12345678",
               core_encrypt, core_decrypt, core_num_rounds, core_d_in);
    end
    wait_rsp(cyc);
    checks++;
    if (cyc !== 7) begin
      errors++;
      $display("FAIL enc_latency: %0d cycles required 7", cyc);
    end
    check_rsp("enc_rsp");
    handshake();
    checks++;
    if (enc_cnt - e0 !== 1 || dec_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL enc_pulses: enc=%0d dec=%0d required 1 0", enc_cnt - e0, dec_cnt - d0);
    end
  endtask

  task automatic test_decrypt_backpressure();
    int e0 = enc_cnt, d0 = dec_cnt, cyc, bad = 0;
    do_accept(1'b1, 5'd31, 32'hFFFFFFFF, 1'b0);
    wait_rsp(cyc);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (host.rsp_valid !== 1'b1 || host.rsp_data !== 32'hA5A5A5A5 || host.req_ready !== 1'b0)
      begin
        errors++;
        $display("FAIL dec_hold: cycle %0d valid=%b data=%h ready=%b required 1 a5a5a5a5 0", i,
                 host.rsp_valid, host.rsp_data, host.req_ready);
      end
      @(posedge clk); #1;
    end
    check_rsp("dec_rsp");
    handshake();
    checks++;
    if (enc_cnt - e0 !== 0 || dec_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL dec_pulses: enc=%0d dec=%0d required 0 1", enc_cnt - e0, dec_cnt - d0);
    end
  endtask

  task automatic test_illegal_rounds();
    int e0 = enc_cnt, d0 = dec_cnt;
    do_accept(1'b0, 5'd0, 32'hDEADBEEF, 1'b0);
    checks++;
    if (host.rsp_valid !== 1'b1 || core_encrypt !== 1'b0 || core_decrypt !== 1'b0) begin
      errors++;
      $display("FAIL illegal_next_cycle: valid=%b enc/dec=%b%b required 1 00", host.rsp_valid,
               core_encrypt, core_decrypt);
    end
    check_rsp("illegal_rsp");
    handshake();
    checks++;
    if (enc_cnt != e0 || dec_cnt != d0) begin
      errors++;
      $display("FAIL illegal_pulses: enc=%0d dec=%0d required 0 0", enc_cnt - e0, dec_cnt - d0);
    end
  endtask

  task automatic test_stray_and_midreset();
    int cyc;
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || host.rsp_valid !== 1'b0 || host.rsp_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL stray_idle: busy=%b valid=%b data=%h required 0 0 deadbeef", busy,
               host.rsp_valid, host.rsp_data);
    end
    do_accept(1'b0, 5'd8, 32'h0F0F0F0F, 1'b0);
    wait_rsp(cyc);
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (host.rsp_valid !== 1'b1 || host.rsp_data !== 32'hAAAAAAAA) begin
      errors++;
      $display("FAIL stray_resp: valid=%b data=%h required 1 aaaaaaaa", host.rsp_valid,
               host.rsp_data);
    end
    check_rsp("stray_rsp");
    handshake();
    // Reset two cycles after the start pulse; the model's done still arrives later.
    do_accept(1'b1, 5'd20, 32'h01020304, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({host.req_ready, host.rsp_valid, host.rsp_data, host.rsp_err, core_encrypt, core_decrypt,
         core_num_rounds, core_key, core_d_in, busy} !== '0) begin
      errors++;
      $display("FAIL midreset_values: rounds=%0d d_in=%h busy=%b required all 0",
               core_num_rounds, core_d_in, busy);
    end
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    checks++;
    if (host.rsp_valid !== 1'b0 || busy !== 1'b0 || host.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL late_done_ignored: valid=%b busy=%b ready=%b required 0 0 1",
               host.rsp_valid, busy, host.req_ready);
    end
    do_accept(1'b0, 5'd5, 32'h00000000, 1'b0);
    wait_rsp(cyc);
    checks++;
    if (cyc !== 7) begin
      errors++;
      $display("FAIL post_reset_latency: %0d cycles required 7", cyc);
    end
    check_rsp("post_reset_rsp");
    handshake();
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_accept(1'b0, 5'd1, 32'hFFFF0000, 1'b0);
    wait_rsp(cyc);
    check_rsp("b2b_first");
    handshake();
    do_accept(1'b1, 5'd2, 32'h0000FFFF, 1'b0);
    checks++;
    if (core_decrypt !== 1'b1 || core_d_in !== 32'h0000FFFF) begin
      errors++;
      $display("FAIL b2b_start: dec=%b d_in=%h required 1 0000ffff", core_decrypt, core_d_in);
    end
    wait_rsp(cyc);
    checks++;
    if (cyc !== 7) begin
      errors++;
      $display("FAIL b2b_latency: %0d cycles required 7", cyc);
    end
    check_rsp("b2b_second");
    handshake();
  endtask

`ifdef RC5_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    model_delay = 0;
    do_accept(1'b0, 5'd10, 32'h11111111, 1'b1);
    wait_rsp(cyc);
    checks++;
    if (cyc !== 10) begin
      errors++;
      $display("FAIL timeout_latency: %0d cycles required 10", cyc);
    end
    check_rsp("timeout_rsp");
    handshake();
    model_delay = 8;
    do_accept(1'b1, 5'd10, 32'h22222222, 1'b0);
    wait_rsp(cyc);
    checks++;
    if (cyc !== 10) begin
      errors++;
      $display("FAIL done_at_expiry_latency: %0d cycles required 10", cyc);
    end
    check_rsp("done_at_expiry_rsp");
    handshake();
    model_delay = 5;
  endtask
`endif

  initial begin
    host.req_valid  = 1'b0;
    host.req_dir    = 1'b0;
    host.req_rounds = '0;
    host.req_key    = '0;
    host.req_data   = '0;
    host.rsp_ready  = 1'b0;
    test_reset();
    test_encrypt();
    test_decrypt_backpressure();
    test_illegal_rounds();
    test_stray_and_midreset();
    test_back_to_back();
`ifdef RC5_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (both_cnt !== 0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL final_state: both_pulses=%0d pending=%0d required 0 0", both_cnt,
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
